// File: rtl/if_fetch_pair.sv
// if_fetch_pair: two-wide fetch stage, one aligned 64-bit request in flight, pair written to the IB.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
package if_fetch_pair_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;
endpackage

module if_fetch_pair
  import if_fetch_pair_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic [31:0] squash_pc,
  input  logic        ib_full,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output IF_IB_PACKET if_ib_packet [0:1],
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 64;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DLEN-1:0]   hold_q, hold_d;
  IF_IB_PACKET       pkt_q [0:1];
  IF_IB_PACKET       pkt_d [0:1];
  logic              req_valid_q, req_valid_d;
  logic              load_resp_c, load_hold_c, capture_c, deliver_c;
  logic [DLEN-1:0]   src_data_c;
  logic [XLEN-1:0]   base_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Squash wins; a request already accepted leaves a response that must be drained in DROP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (mem_req_ready) state_d = squash ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (squash)              state_d = mem_resp_valid ? S_REQ : S_DROP;
        else if (mem_resp_valid) state_d = ib_full ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        if (squash || !ib_full) state_d = S_REQ;
      end
      S_DROP: begin
        if (mem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    load_resp_c = 1'b0;
    load_hold_c = 1'b0;
    capture_c   = 1'b0;
    case (state_q)
      S_WAIT: begin
        load_resp_c = !squash && mem_resp_valid && !ib_full;
        capture_c   = !squash && mem_resp_valid && ib_full;
      end
      S_HOLD:  load_hold_c = !squash && !ib_full;
      default: ;
    endcase
  end

  // Pair formation from the fetch PC and either the live response or the held doubleword.
  always_comb begin
    deliver_c   = load_resp_c || load_hold_c;
    src_data_c  = load_hold_c ? hold_q : mem_resp_data;
    base_c      = {pc_q[XLEN-1:3], 3'b000};
    pc_d        = pc_q;
    hold_d      = capture_c ? mem_resp_data : hold_q;
    pkt_d[0]    = pkt_q[0];
    pkt_d[1]    = pkt_q[1];
    pkt_d[0].valid = 1'b0;
    pkt_d[1].valid = 1'b0;
    if (deliver_c) begin
      pkt_d[0].valid = 1'b1;
      pkt_d[0].inst  = pc_q[2] ? src_data_c[63:32] : src_data_c[31:0];
      pkt_d[0].PC    = pc_q;
      pkt_d[0].NPC   = pc_q + 32'd4;
      if (pc_q[2]) begin
        pkt_d[1] = '0;
      end else begin
        pkt_d[1].valid = 1'b1;
        pkt_d[1].inst  = src_data_c[63:32];
        pkt_d[1].PC    = pc_q + 32'd4;
        pkt_d[1].NPC   = pc_q + 32'd8;
      end
      pc_d = base_c + 32'd8;
    end
    if (squash) pc_d = squash_pc;
    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      hold_q      <= '0;
      pkt_q[0]    <= '0;
      pkt_q[1]    <= '0;
      req_valid_q <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      pkt_q[0]    <= pkt_d[0];
      pkt_q[1]    <= pkt_d[1];
      req_valid_q <= req_valid_d;
    end
  end

  assign mem_req_valid   = req_valid_q;
  assign mem_req_addr    = {pc_q[XLEN-1:3], 3'b000};
  assign if_ib_packet[0] = pkt_q[0];
  assign if_ib_packet[1] = pkt_q[1];

`ifdef FETCH_PERF_EN
  logic            drop_c;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d, drop_cnt_q, drop_cnt_d;

  // A drop is any response or held doubleword discarded because of a squash.
  always_comb begin
    drop_c = 1'b0;
    case (state_q)
      S_WAIT:  drop_c = squash && mem_resp_valid;
      S_HOLD:  drop_c = squash;
      S_DROP:  drop_c = mem_resp_valid;
      default: drop_c = 1'b0;
    endcase
    fetch_cnt_d = fetch_cnt_q + XLEN'(deliver_c);
    drop_cnt_d  = drop_cnt_q + XLEN'(drop_c);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_pair.sv
// tb_if_fetch_pair: directed + random bench for if_fetch_pair with a transaction-level reference model.
module tb_if_fetch_pair;
  import if_fetch_pair_pkg::*;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [31:0] squash_pc;
  logic        ib_full;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  IF_IB_PACKET pkt [0:1];
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;

  if_fetch_pair #(.RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .squash_pc      (squash_pc),
    .ib_full        (ib_full),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .if_ib_packet   (pkt),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: fetch PC, one outstanding request (possibly doomed by a squash), held data.
  logic [31:0] m_pc;
  bit          m_outst, m_doomed, m_held;
  logic [63:0] m_hold_data;
  IF_IB_PACKET m_pkt [0:1];
  logic [31:0] m_fetch, m_drop;
  int          lat;

  function automatic IF_IB_PACKET mkp(input logic v, input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] n);
    IF_IB_PACKET r;
    r.valid = v; r.inst = i; r.PC = p; r.NPC = n;
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input IF_IB_PACKET obs, input IF_IB_PACKET exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_outst = 0; m_doomed = 0; m_held = 0; m_hold_data = '0;
    m_pkt[0] = '0; m_pkt[1] = '0; m_fetch = 0; m_drop = 0; lat = 0;
  endtask

  task automatic check_all(input string tag);
    chk32({tag, "_req_valid"}, 32'(mem_req_valid), 32'(!(m_outst || m_held)));
    chk32({tag, "_req_addr"}, mem_req_addr, {m_pc[31:3], 3'b000});
    chkp({tag, "_slot0"}, pkt[0], m_pkt[0]);
    chkp({tag, "_slot1"}, pkt[1], m_pkt[1]);
    chk32({tag, "_fetch_cnt"}, perf_fetch_cnt, PERF ? m_fetch : 32'h0);
    chk32({tag, "_drop_cnt"}, perf_drop_cnt, PERF ? m_drop : 32'h0);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check after the edge.
  task automatic step(input string tag, input logic sq, input logic [31:0] sp, input logic full,
                      input logic rdy, input logic rv, input logic [63:0] data);
    bit          deliver;
    logic [63:0] src;
    logic [31:0] words [2];
    int          idx;
    squash = sq; squash_pc = sp; ib_full = full;
    mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = data;
    deliver = 0; src = data;
    m_pkt[0].valid = 1'b0; m_pkt[1].valid = 1'b0;
    if (m_held) begin
      if (sq) begin m_held = 0; m_drop++; end
      else if (!full) begin m_held = 0; deliver = 1; src = m_hold_data; end
    end else if (m_outst) begin
      if (rv) begin
        m_outst = 0;
        if (sq || m_doomed) m_drop++;
        else if (full) begin m_held = 1; m_hold_data = data; end
        else deliver = 1;
        m_doomed = 0;
      end else if (sq) begin
        m_doomed = 1;
      end
    end else if (rdy) begin
      m_outst = 1; m_doomed = sq;
    end
    if (deliver) begin
      words[0] = src[31:0]; words[1] = src[63:32];
      idx = int'(m_pc[2]);
      m_pkt[0] = mkp(1'b1, words[idx], m_pc, m_pc + 32'd4);
      m_pkt[1] = (idx == 0) ? mkp(1'b1, words[1], m_pc + 32'd4, m_pc + 32'd8) : '0;
      m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
      m_fetch++;
    end
    if (sq) m_pc = sp;
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  logic [63:0] d;
  bit          was_outst;
  logic        r_sq, r_full, r_rdy, r_rv;
  logic [31:0] r_sp;

  initial begin
    reset = 1'b1; squash = 0; squash_pc = '0; ib_full = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all("reset");
    chkp("reset_slot0_zero", pkt[0], '0);
    chk32("reset_req_valid", 32'(mem_req_valid), 32'd1);

    // Basic fetch from PC 0, latency 2.
    d = 64'hBBBB_BBBB_AAAA_AAAA;
    step("t1_acc", 0, 0, 0, 1, 0, '0);
    step("t1_wait", 0, 0, 0, 0, 0, '0);
    step("t1_resp", 0, 0, 0, 0, 1, d);
    chkp("t1_slot0", pkt[0], mkp(1'b1, 32'hAAAA_AAAA, 32'h0, 32'h4));
    chkp("t1_slot1", pkt[1], mkp(1'b1, 32'hBBBB_BBBB, 32'h4, 32'h8));
    chk32("t1_next_addr", mem_req_addr, 32'h8);
    step("t1_idle", 0, 0, 0, 0, 0, '0);
    chk32("t1_valid_one_cycle", 32'(pkt[0].valid), 32'd0);

    // Squash to an odd-word PC while idle in REQ.
    d = 64'h1111_2222_3333_4444;
    step("t2_sq", 1, 32'h104, 0, 0, 0, '0);
    chk32("t2_addr", mem_req_addr, 32'h100);
    step("t2_acc", 0, 0, 0, 1, 0, '0);
    step("t2_resp", 0, 0, 0, 0, 1, d);
    chkp("t2_slot0", pkt[0], mkp(1'b1, 32'h1111_2222, 32'h104, 32'h108));
    chkp("t2_slot1", pkt[1], '0);
    chk32("t2_next_addr", mem_req_addr, 32'h108);

    // Squash in WAIT; response three cycles later is dropped.
    step("t3_acc", 0, 0, 0, 1, 0, '0);
    step("t3_sq", 1, 32'h200, 0, 0, 0, '0);
    step("t3_w1", 0, 0, 0, 0, 0, '0);
    step("t3_w2", 0, 0, 0, 0, 0, '0);
    step("t3_resp", 0, 0, 0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF);
    chk32("t3_no_valid", 32'(pkt[0].valid | pkt[1].valid), 32'd0);
    chk32("t3_drop", perf_drop_cnt, PERF ? 32'd1 : 32'd0);
    chk32("t3_addr", mem_req_addr, 32'h200);

    // Buffer full for four cycles at response time.
    d = 64'h5555_6666_7777_8888;
    step("t4_acc", 0, 0, 0, 1, 0, '0);
    step("t4_resp", 0, 0, 1, 0, 1, d);
    for (int i = 0; i < 3; i++) begin
      step("t4_full", 0, 0, 1, 0, 0, '0);
      chk32("t4_no_valid", 32'(pkt[0].valid), 32'd0);
    end
    step("t4_release", 0, 0, 0, 0, 0, '0);
    chkp("t4_slot0", pkt[0], mkp(1'b1, 32'h7777_8888, 32'h200, 32'h204));
    chkp("t4_slot1", pkt[1], mkp(1'b1, 32'h5555_6666, 32'h204, 32'h208));

    // Squash coincident with response in WAIT.
    step("t5_acc", 0, 0, 0, 1, 0, '0);
    step("t5_sqresp", 1, 32'h300, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
    chk32("t5_no_valid", 32'(pkt[0].valid | pkt[1].valid), 32'd0);
    chk32("t5_req_valid", 32'(mem_req_valid), 32'd1);
    chk32("t5_addr", mem_req_addr, 32'h300);
    chk32("t5_drop", perf_drop_cnt, PERF ? 32'd2 : 32'd0);

    // Address wrap at the top of memory.
    d = 64'hCAFE_0001_F00D_0002;
    step("t6_sq", 1, 32'hFFFF_FFF8, 0, 0, 0, '0);
    step("t6_acc", 0, 0, 0, 1, 0, '0);
    step("t6_resp", 0, 0, 0, 0, 1, d);
    chkp("t6_slot0", pkt[0], mkp(1'b1, 32'hF00D_0002, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
    chkp("t6_slot1", pkt[1], mkp(1'b1, 32'hCAFE_0001, 32'hFFFF_FFFC, 32'h0));
    chk32("t6_addr_wrap", mem_req_addr, 32'h0);

    // Randomized traffic against an in-order memory with 1-4 cycle latency.
    lat = 0;
    for (int c = 0; c < 400; c++) begin
      r_sq   = ($urandom_range(0, 11) == 0);
      r_sp   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                           : 32'($urandom());
      r_full = ($urandom_range(0, 2) == 0);
      r_rdy  = 1'($urandom_range(0, 1));
      r_rv   = m_outst && (lat == 0);
      d      = {32'($urandom()), 32'($urandom())};
      was_outst = m_outst;
      step("rnd", r_sq, r_sp, r_full, r_rdy, r_rv, d);
      if (!was_outst && m_outst) lat = $urandom_range(0, 3);
      else if (m_outst && lat > 0) lat--;
    end

    // Asynchronous reset while a request is outstanding.
    step("ar_idle", 0, 0, 0, 0, 0, '0);
    if (!(m_outst || m_held)) step("ar_acc", 0, 0, 0, 1, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk32("arst_req_valid", 32'(mem_req_valid), 32'd1);
    check_all("arst");
    @(negedge clock);
    reset = 1'b0;
    step("ar_acc2", 0, 0, 0, 1, 0, '0);
    step("ar_resp", 0, 0, 0, 0, 1, 64'h2222_2222_1111_1111);
    chkp("ar_slot0", pkt[0], mkp(1'b1, 32'h1111_1111, 32'h0, 32'h4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
